// File: rtl/ysyx_23060072_ifu_mem_bridge.sv
// Fetch-side bridge: single-outstanding memory fetches with a 2-entry PC-tagged response FIFO.
// Optional memory timeout enabled by defining YSYX_23060072_IFU_TIMEOUT_EN.
module ysyx_23060072_ifu_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_addr_o,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_fault_o,
    input  logic        rsp_ready_i,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_rdata_i,
    input  logic        mem_rsp_err_i
);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_reg, state_next;
    logic        drop_reg, drop_next;
    logic [31:0] addr_reg;
    logic [1:0]  count_reg;
    logic        wr_ptr_reg, rd_ptr_reg;
    logic [31:0] fifo_addr  [2];
    logic [31:0] fifo_instr [2];
    logic        fifo_fault [2];

    logic        accept, timeout, done, push, pop, push_ok;
    logic [31:0] push_instr;

`ifdef YSYX_23060072_IFU_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;

    // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt_reg <= '0;
        else if (state_reg != S_WAIT)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
    end

    assign timeout = (state_reg == S_WAIT) && !mem_rsp_valid_i &&
                     (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign req_ready_o     = (state_reg == S_IDLE) && (count_reg < 2'd2) && !flush_i;
    assign accept          = req_valid_i && req_ready_o;
    assign mem_req_valid_o = (state_reg == S_REQ);
    assign mem_req_addr_o  = addr_reg;

    assign done       = (state_reg == S_WAIT) && (mem_rsp_valid_i || timeout);
    assign push_ok    = mem_rsp_valid_i && !mem_rsp_err_i;
    assign push_instr = push_ok ? mem_rsp_rdata_i : EBREAK;
    assign push       = done && !drop_reg && !flush_i;
    assign pop        = (count_reg != 2'd0) && rsp_ready_i && !flush_i;

    always_comb begin
        state_next = state_reg;
        drop_next  = drop_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept)
                    state_next = S_REQ;
            end
            S_REQ: begin
                if (flush_i)
                    drop_next = 1'b1;
                if (mem_req_ready_i)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completing transaction always clears drop, even if flushed this cycle.
                if (done) begin
                    state_next = S_IDLE;
                    drop_next  = 1'b0;
                end else if (flush_i) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                drop_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            drop_reg  <= 1'b0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
            if (accept)
                addr_reg <= req_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else if (flush_i) begin
            count_reg  <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            if (push && !pop)
                count_reg <= count_reg + 2'd1;
            else if (pop && !push)
                count_reg <= count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_reg]  <= addr_reg;
            fifo_instr[wr_ptr_reg] <= push_instr;
            fifo_fault[wr_ptr_reg] <= !push_ok;
        end
    end

    // Head fields are forced to zero while empty so outputs are clean out of reset.
    assign rsp_valid_o = (count_reg != 2'd0);
    assign rsp_addr_o  = rsp_valid_o ? fifo_addr[rd_ptr_reg]  : 32'h0;
    assign rsp_instr_o = rsp_valid_o ? fifo_instr[rd_ptr_reg] : 32'h0;
    assign rsp_fault_o = rsp_valid_o ? fifo_fault[rd_ptr_reg] : 1'b0;

endmodule
